// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle phase sequencer: states, one-hot phase
// bit positions and the latency-counter width with its load-value helper.
package cpu_pkg;

    localparam int LAT_W = 4;
    localparam int PH_W  = 5;

    typedef enum logic [2:0] {
        S_HALTED  = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_WB      = 3'd5
    } state_t;

    localparam int PH_FETCH   = 0;
    localparam int PH_DECODE  = 1;
    localparam int PH_EXECUTE = 2;
    localparam int PH_MEMORY  = 3;
    localparam int PH_WB      = 4;

    // A latency of N cycles loads N-1; 0 behaves as 1 and values past 15 saturate.
    function automatic logic [LAT_W-1:0] lat_load(input int lat);
        if (lat <= 1)
            return '0;
        else if (lat > 15)
            return LAT_W'(14);
        else
            return LAT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter shared by FETCH and MEMORY to stretch a phase; done
// is high while the count is zero, i.e. in the last cycle of the phase.
module lat_counter
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Single-clock phase sequencer for the multi-cycle MIPS datapath: produces the
// per-phase enables, run/halt/single-step control and a retired-instruction count.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int IMEM_LAT  = 1,
    parameter int DMEM_LAT  = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic                 mem_access,
    input  logic                 mem_write,
    input  logic                 reg_write,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic                 dmem_wren,
    output logic                 rf_wren,
    output logic [PH_W-1:0]      phase,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [LAT_W-1:0] IMEM_LOAD = lat_load(IMEM_LAT);
    localparam logic [LAT_W-1:0] DMEM_LOAD = lat_load(DMEM_LAT);

    state_t           state, state_nxt;
    logic             step_q, step_nxt;
    logic             mem_access_q, mem_write_q, reg_write_q;
    logic             cnt_load;
    logic [LAT_W-1:0] cnt_load_val;
    logic [LAT_W-1:0] cnt;
    logic             cnt_done;

    lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_HALTED;
            step_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= step_nxt;
        end
    end

    // Controller bits are only trusted while the fetched instruction is in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_access_q <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
        end else if (state == S_DECODE) begin
            mem_access_q <= mem_access;
            mem_write_q  <= mem_write;
            reg_write_q  <= reg_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired <= '0;
        else if (state == S_WB)
            retired <= retired + 1'b1;
    end

    // The counter is loaded on the transition into FETCH or MEMORY.
    always_comb begin
        state_nxt    = state;
        step_nxt     = step_q;
        cnt_load     = 1'b0;
        cnt_load_val = IMEM_LOAD;
        case (state)
            S_HALTED: begin
                if (run) begin
                    state_nxt = S_FETCH;
                    step_nxt  = 1'b0;
                    cnt_load  = 1'b1;
                end else if (step) begin
                    state_nxt = S_FETCH;
                    step_nxt  = 1'b1;
                    cnt_load  = 1'b1;
                end
            end
            S_FETCH: begin
                if (cnt_done)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (mem_access_q) begin
                    state_nxt    = S_MEMORY;
                    cnt_load     = 1'b1;
                    cnt_load_val = DMEM_LOAD;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEMORY: begin
                if (cnt_done)
                    state_nxt = S_WB;
            end
            S_WB: begin
                step_nxt = 1'b0;
                if (!run || step_q) begin
                    state_nxt = S_HALTED;
                end else begin
                    state_nxt = S_FETCH;
                    cnt_load  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_HALTED;
                step_nxt  = 1'b0;
            end
        endcase
    end

    // Counter still holds its load value only in the first MEMORY cycle.
    always_comb begin
        phase     = '0;
        ir_en     = (state == S_FETCH) && cnt_done;
        pc_en     = (state == S_WB);
        rf_wren   = (state == S_WB) && reg_write_q;
        dmem_wren = (state == S_MEMORY) && mem_write_q && (cnt == DMEM_LOAD);
        halted    = (state == S_HALTED);
        case (state)
            S_FETCH:   phase[PH_FETCH]   = 1'b1;
            S_DECODE:  phase[PH_DECODE]  = 1'b1;
            S_EXECUTE: phase[PH_EXECUTE] = 1'b1;
            S_MEMORY:  phase[PH_MEMORY]  = 1'b1;
            S_WB:      phase[PH_WB]      = 1'b1;
            default:   phase             = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-cycle expected output traces are queued as each
// scenario is driven and compared at every falling clock edge.
module tb_cpu_sequencer;

  localparam int TB_IMEM = 2;
  localparam int TB_DMEM = 3;
  localparam int CW      = 32;
  localparam int W       = 10 + CW;

  logic          clk = 1'b0;
  logic          rst, run, step, mem_access, mem_write, reg_write;
  logic          ir_en, pc_en, dmem_wren, rf_wren, halted;
  logic [4:0]    phase;
  logic [CW-1:0] retired;

  cpu_sequencer #(
    .IMEM_LAT  (TB_IMEM),
    .DMEM_LAT  (TB_DMEM),
    .CNT_WIDTH (CW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .mem_access (mem_access),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .dmem_wren  (dmem_wren),
    .rf_wren    (rf_wren),
    .phase      (phase),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_obs, mon_exp;
  logic [CW-1:0] model_ret;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic [W-1:0] pack(input logic h, input logic [4:0] ph,
      input logic ir, input logic pc, input logic dw, input logic rw,
      input logic [CW-1:0] r);
    return {h, ph, ir, pc, dw, rw, r};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_obs = pack(halted, phase, ir_en, pc_en, dmem_wren, rf_wren, retired);
      n_checks++;
      if (mon_obs !== mon_exp)
        $display("FAIL sb_cycle t=%0t {halted,phase,ir,pc,dw,rw,retired} got=%h exp=%h",
                 $time, mon_obs, mon_exp);
      else
        n_pass++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(pack(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, model_ret));
  endtask

  task automatic push_instr(input logic ma, input logic mw, input logic rw);
    for (int i = 0; i < TB_IMEM; i++)
      exp_q.push_back(pack(1'b0, 5'b00001, (i == TB_IMEM - 1), 1'b0, 1'b0, 1'b0, model_ret));
    exp_q.push_back(pack(1'b0, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, model_ret));
    exp_q.push_back(pack(1'b0, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, model_ret));
    if (ma)
      for (int j = 0; j < TB_DMEM; j++)
        exp_q.push_back(pack(1'b0, 5'b01000, 1'b0, 1'b0, (j == 0) && mw, 1'b0, model_ret));
    exp_q.push_back(pack(1'b0, 5'b10000, 1'b0, 1'b1, 1'b0, rw, model_ret));
    model_ret = model_ret + 1'b1;
  endtask

  task automatic set_ctrl(input logic ma, input logic mw, input logic rw);
    mem_access = ma;
    mem_write  = mw;
    reg_write  = rw;
  endtask

  // The monitor pops one entry every cycle, so this always terminates.
  task automatic drain();
    while (exp_q.size() != 0) wait_cycles(1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0);
    model_ret = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (halted !== 1'b1) $display("FAIL reset_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (phase !== 5'b0) $display("FAIL reset_phase got=%b exp=00000", phase); else n_pass++;
    n_checks++;
    if ({ir_en, pc_en, dmem_wren, rf_wren} !== 4'b0)
      $display("FAIL reset_enables got=%b exp=0000", {ir_en, pc_en, dmem_wren, rf_wren});
    else n_pass++;
    n_checks++; if (retired !== '0) $display("FAIL reset_retired got=%0d exp=0", retired); else n_pass++;
    rst = 1'b0;
    wait_cycles(1);
    n_checks++; if (halted !== 1'b1) $display("FAIL reset_idle_halted got=%b exp=1", halted); else n_pass++;
  endtask

  task automatic test_basic();
    set_ctrl(1'b0, 1'b0, 1'b1);
    run = 1'b1;
    push_halt(1);
    push_instr(1'b0, 1'b0, 1'b1);
    push_instr(1'b0, 1'b0, 1'b1);
    wait_cycles(TB_IMEM + 5);
    run = 1'b0;
    push_halt(2);
    drain();
    n_checks++; if (halted !== 1'b1) $display("FAIL basic_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (retired !== model_ret) $display("FAIL basic_retired got=%0d exp=%0d", retired, model_ret); else n_pass++;
  endtask

  task automatic test_halt_mid_load();
    set_ctrl(1'b1, 1'b0, 1'b1);
    run = 1'b1;
    push_halt(1);
    push_instr(1'b1, 1'b0, 1'b1);
    push_halt(2);
    wait_cycles(TB_IMEM + 2);
    n_checks++;
    if (phase !== 5'b00100) $display("FAIL halt_mid_in_execute got=%b exp=00100", phase); else n_pass++;
    run = 1'b0;
    drain();
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_mid_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (retired !== model_ret) $display("FAIL halt_mid_retired got=%0d exp=%0d", retired, model_ret); else n_pass++;
  endtask

  task automatic test_store();
    int n;
    set_ctrl(1'b1, 1'b1, 1'b0);
    run = 1'b1;
    push_halt(1);
    push_instr(1'b1, 1'b1, 1'b0);
    push_halt(1);
    wait_cycles(1);
    run = 1'b0;
    n = 1;
    while (!halted && n < 100) begin
      wait_cycles(1);
      n++;
    end
    n_checks++;
    if (n != TB_IMEM + TB_DMEM + 4)
      $display("FAIL store_latency got=%0d exp=%0d", n - 1, TB_IMEM + TB_DMEM + 3);
    else n_pass++;
    drain();
    n_checks++; if (retired !== model_ret) $display("FAIL store_retired got=%0d exp=%0d", retired, model_ret); else n_pass++;
  endtask

  task automatic test_step();
    set_ctrl(1'b0, 1'b0, 1'b1);
    run = 1'b0;
    step = 1'b1;
    push_halt(1);
    push_instr(1'b0, 1'b0, 1'b1);
    push_halt(2);
    wait_cycles(1);
    step = 1'b0;
    wait_cycles(1);
    step = 1'b1;
    wait_cycles(1);
    step = 1'b0;
    wait_cycles(TB_IMEM + 2);
    n_checks++; if (halted !== 1'b1) $display("FAIL step_between_halted got=%b exp=1", halted); else n_pass++;
    step = 1'b1;
    push_instr(1'b0, 1'b0, 1'b1);
    push_halt(2);
    wait_cycles(1);
    step = 1'b0;
    drain();
    n_checks++; if (halted !== 1'b1) $display("FAIL step_end_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (retired !== model_ret) $display("FAIL step_retired got=%0d exp=%0d", retired, model_ret); else n_pass++;
  endtask

  task automatic test_run_step();
    set_ctrl(1'b0, 1'b0, 1'b0);
    run = 1'b1;
    step = 1'b1;
    push_halt(1);
    push_instr(1'b0, 1'b0, 1'b0);
    push_instr(1'b0, 1'b0, 1'b0);
    push_halt(1);
    wait_cycles(1);
    step = 1'b0;
    wait_cycles(TB_IMEM + 4);
    run = 1'b0;
    drain();
    n_checks++; if (retired !== model_ret) $display("FAIL run_step_retired got=%0d exp=%0d", retired, model_ret); else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    int n;
    set_ctrl(1'b1, 1'b1, 1'b0);
    run = 1'b1;
    n = 0;
    while (phase !== 5'b01000 && n < 100) begin
      wait_cycles(1);
      n++;
    end
    n_checks++; if (n != TB_IMEM + 3) $display("FAIL rst_mid_reach_mem got=%0d exp=%0d", n, TB_IMEM + 3); else n_pass++;
    n_checks++; if (dmem_wren !== 1'b1) $display("FAIL rst_mid_wren_before got=%b exp=1", dmem_wren); else n_pass++;
    #2;
    rst = 1'b1;
    model_ret = '0;
    #1;
    n_checks++; if (dmem_wren !== 1'b0) $display("FAIL rst_mid_wren_drop got=%b exp=0", dmem_wren); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL rst_mid_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (retired !== '0) $display("FAIL rst_mid_retired got=%0d exp=0", retired); else n_pass++;
    n_checks++; if (phase !== 5'b0) $display("FAIL rst_mid_phase got=%b exp=00000", phase); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ir_en, pc_en, dmem_wren, rf_wren} !== 4'b0)
      $display("FAIL rst_mid_next_enables got=%b exp=0000", {ir_en, pc_en, dmem_wren, rf_wren});
    else n_pass++;
    rst = 1'b0;
    n = 0;
    while (!ir_en && n < 100) begin
      wait_cycles(1);
      n++;
    end
    n_checks++; if (n != TB_IMEM) $display("FAIL rst_mid_first_ir got=%0d exp=%0d", n, TB_IMEM); else n_pass++;
    run = 1'b0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_halt_mid_load();
    test_store();
    test_step();
    test_run_step();
    test_reset_mid_store();
    wait_cycles(TB_IMEM + TB_DMEM + 6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
